// File: rtl/key_irq_service_ctrl_if.sv
// Avalon-MM bus bundle between the key service controller and the key PIO.
// The master drives the access; the slave returns registered read data.
interface key_irq_service_ctrl_if;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_readdata
    );
endinterface

// File: rtl/key_irq_service_ctrl.sv
// Key PIO irq service: read/clear edge_capture, sample levels, queue events in a FWFT FIFO.
// Optional KEY_SVC_TIMESTAMP_EN adds a 16-bit cycle timestamp per event on evt_ts.
module key_irq_service_ctrl #(
    parameter logic [3:0] IRQ_MASK_INIT = 4'hF,
    parameter int         RD_LATENCY    = 1,
    parameter int         FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    key_irq_service_ctrl_if.master bus,
    input  logic                   irq_in,
    input  logic                   mask_wr,
    input  logic [3:0]             mask_val,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [3:0]             evt_edges,
    output logic [3:0]             evt_level,
    output logic [7:0]             drop_cnt,
    output logic                   busy
`ifdef KEY_SVC_TIMESTAMP_EN
    ,
    output logic [15:0]            evt_ts
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEY_SVC_TIMESTAMP_EN
    localparam int EW = 24;
`else
    localparam int EW = 8;
`endif
    localparam logic [1:0] RL = 2'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_INIT, S_CLR0, S_IDLE, S_MASKW,
        S_RDCAP, S_CLRCAP, S_RDLVL, S_PUSH
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [3:0]    cap_q, cap_d;
    logic [3:0]    lvl_q, lvl_d;
    logic [3:0]    mval_q, mval_d;
    logic          mpend_q, mpend_d;
    logic          cs_q, cs_d;
    logic          wn_q, wn_d;
    logic [1:0]    addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [EW-1:0] hold_q, hold_d;
    logic [7:0]    drop_q, drop_d;
    logic [EW-1:0] head, entry, disp;
    logic          push, empty, full, pop, wr_en;
    logic [3:0]    rd_nib;
    logic          unused_rd;

    assign rd_nib    = bus.m_readdata[3:0];
    assign unused_rd = ^bus.m_readdata[31:4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        lvl_d   = lvl_q;
        mval_d  = mval_q;
        mpend_d = mpend_q;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = addr_q;
        wd_d    = wd_q;
        push    = 1'b0;
        if (mask_wr) begin
            mval_d  = mask_val;
            mpend_d = 1'b1;
        end
        unique case (state_q)
            S_INIT: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 2'd2;
                wd_d    = {28'h0, IRQ_MASK_INIT};
                state_d = S_CLR0;
            end
            S_CLR0: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 2'd3;
                wd_d    = 32'h0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                // irq waits while a write is still on the bus: capture may be stale
                if (mask_wr || mpend_q) begin
                    mpend_d = 1'b0;
                    state_d = S_MASKW;
                end else if (irq_in && !cs_q) begin
                    cnt_d   = 2'd0;
                    state_d = S_RDCAP;
                end
            end
            S_MASKW: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 2'd2;
                wd_d    = {28'h0, mval_q};
                state_d = S_IDLE;
            end
            S_RDCAP: begin
                if (cnt_q == 2'd0) begin
                    cs_d   = 1'b1;
                    addr_d = 2'd3;
                end
                if (cnt_q == RL) begin
                    cap_d   = rd_nib;
                    cnt_d   = 2'd0;
                    state_d = (rd_nib == 4'h0) ? S_IDLE : S_CLRCAP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_CLRCAP: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 2'd3;
                wd_d    = 32'h0;
                cnt_d   = 2'd0;
                state_d = S_RDLVL;
            end
            S_RDLVL: begin
                if (cnt_q == 2'd0) begin
                    cs_d   = 1'b1;
                    addr_d = 2'd0;
                end
                if (cnt_q == RL) begin
                    lvl_d   = rd_nib;
                    cnt_d   = 2'd0;
                    state_d = S_PUSH;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            cnt_q   <= 2'd0;
            cap_q   <= 4'h0;
            lvl_q   <= 4'h0;
            mval_q  <= 4'h0;
            mpend_q <= 1'b0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= 2'd0;
            wd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            lvl_q   <= lvl_d;
            mval_q  <= mval_d;
            mpend_q <= mpend_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

`ifdef KEY_SVC_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;
    logic [15:0] tsc_q, tsc_d;

    always_comb begin
        ts_d  = ts_q + 16'd1;
        tsc_d = tsc_q;
        if (state_q == S_RDCAP && cnt_q == 2'd0) tsc_d = ts_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q  <= 16'h0;
            tsc_q <= 16'h0;
        end else begin
            ts_q  <= ts_d;
            tsc_q <= tsc_d;
        end
    end

    assign entry  = {tsc_q, cap_q, lvl_q};
    assign evt_ts = disp[23:8];
`else
    assign entry = {cap_q, lvl_q};
`endif

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && evt_ready;
    assign wr_en = push && (!full || pop);
    assign head  = mem_q[rd_q[AW-1:0]];
    assign disp  = empty ? hold_q : head;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_q[AW-1:0]] = entry;
        wr_d   = wr_q + {{AW{1'b0}}, wr_en};
        rd_d   = rd_q + {{AW{1'b0}}, pop};
        hold_d = pop ? head : hold_q;
        drop_d = drop_q;
        if (push && full && !pop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
            drop_q <= 8'h0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            hold_q <= hold_d;
            drop_q <= drop_d;
        end
    end

    assign bus.m_chipselect = cs_q;
    assign bus.m_write_n    = wn_q;
    assign bus.m_address    = addr_q;
    assign bus.m_writedata  = wd_q;
    assign evt_valid        = !empty;
    assign evt_edges        = disp[7:4];
    assign evt_level        = disp[3:0];
    assign drop_cnt         = drop_q;
    assign busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_key_irq_service_ctrl.sv
// Bench for key_irq_service_ctrl: behavioural key PIO, access log and event table.
// Covers init writes, service latency, overflow, mask priority, spurious irq, reset.
module tb_key_irq_service_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       irq_in;
    logic       mask_wr = 1'b0;
    logic [3:0] mask_val = 4'h0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [3:0] evt_edges;
    logic [3:0] evt_level;
    logic [7:0] drop_cnt;
    logic       busy;
`ifdef KEY_SVC_TIMESTAMP_EN
    logic [15:0] evt_ts;
`endif

    key_irq_service_ctrl_if bus ();

    key_irq_service_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_val  (mask_val),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_edges (evt_edges),
        .evt_level (evt_level),
        .drop_cnt  (drop_cnt),
`ifdef KEY_SVC_TIMESTAMP_EN
        .evt_ts    (evt_ts),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // key PIO model: keys toggle on tog, edges captured, write to addr 3 clears
    logic [3:0] pio_keys = 4'h0;
    logic [3:0] pio_cap = 4'h0;
    logic [3:0] pio_mask = 4'h0;
    logic [3:0] tog = 4'h0;
    logic       force_irq = 1'b0;
    logic       wr_now;

    assign wr_now = bus.m_chipselect && !bus.m_write_n;
    assign irq_in = (|(pio_cap & pio_mask)) | force_irq;
    assign bus.m_readdata = {28'h0,
        (bus.m_address == 2'd0) ? pio_keys :
        (bus.m_address == 2'd2) ? pio_mask :
        (bus.m_address == 2'd3) ? pio_cap : 4'h0};

    always @(posedge clk) begin
        pio_keys <= pio_keys ^ tog;
        if (wr_now && bus.m_address == 2'd3) pio_cap <= tog;
        else pio_cap <= pio_cap | tog;
        if (wr_now && bus.m_address == 2'd2) pio_mask <= bus.m_writedata[3:0];
    end

    // access log code: {write, upper data nonzero, addr, write data nibble}
    logic [7:0] acc[$];
    always @(posedge clk) begin
        if (bus.m_chipselect)
            acc.push_back({!bus.m_write_n,
                           !bus.m_write_n && (|bus.m_writedata[31:4]),
                           bus.m_address,
                           bus.m_write_n ? 4'h0 : bus.m_writedata[3:0]});
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] acc_at(input int i);
        return (i < acc.size()) ? acc[i] : 8'hEE;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || irq_in) && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < 40, 1);
    endtask

    task automatic svc(input logic [3:0] t);
        tog = t;
        tick();
        tog = 4'h0;
        wait_idle();
    endtask

    task automatic pop_chk(input string name, input logic [3:0] e, input logic [3:0] l);
        chk({name, "_valid"}, evt_valid, 1);
        chk({name, "_edges"}, evt_edges, e);
        chk({name, "_level"}, evt_level, l);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_cs"}, bus.m_chipselect, 0);
        chk({name, "_wn"}, bus.m_write_n, 1);
        chk({name, "_addr"}, bus.m_address, 0);
        chk({name, "_wd"}, bus.m_writedata, 0);
        chk({name, "_valid"}, evt_valid, 0);
        chk({name, "_edges"}, evt_edges, 0);
        chk({name, "_level"}, evt_level, 0);
        chk({name, "_drop"}, drop_cnt, 0);
        chk({name, "_busy"}, busy, 1);
    endtask

    typedef struct {
        logic [3:0] tog;
        logic [3:0] edges;
        logic [3:0] level;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // keys are 4'b0100 when the table starts
        tbl[0] = '{4'b0001, 4'h1, 4'h5};
        tbl[1] = '{4'b0110, 4'h6, 4'h3};
        tbl[2] = '{4'b1000, 4'h8, 4'hB};
        tbl[3] = '{4'b0011, 4'h3, 4'h8};
        tbl[4] = '{4'b1111, 4'hF, 4'h7};

        repeat (2) tick();
        chk_reset_outs("rst");
        reset_n = 1'b1;
        repeat (3) tick();
        chk("init_n", acc.size(), 2);
        chk("init_w2", acc_at(0), 8'hAF);
        chk("init_w3", acc_at(1), 8'hB0);
        chk("init_busy", busy, 0);

        acc.delete();
        tog = 4'b0100;
        tick();
        tog = 4'h0;
        chk("lat_irq", irq_in, 1);
        repeat (6) tick();
        chk("lat_early", evt_valid, 0);
        tick();
        chk("lat_valid", evt_valid, 1);
        wait_idle();
        chk("svc_n", acc.size(), 3);
        chk("svc_rd3", acc_at(0), 8'h30);
        chk("svc_w3", acc_at(1), 8'hB0);
        chk("svc_rd0", acc_at(2), 8'h00);
        pop_chk("lat", 4'h4, 4'h4);
        chk("lat_empty", evt_valid, 0);

        for (int i = 0; i < 5; i++) svc(tbl[i].tog);
        chk("ovf_drop", drop_cnt, 1);

        // full FIFO: pop lands in the PUSH cycle, so the push is kept
        tog = 4'b1000;
        tick();
        tog = 4'h0;
        repeat (6) tick();
        chk("pp_busy", busy, 1);
        chk("pp_head", evt_edges, tbl[0].edges);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        wait_idle();
        chk("pp_drop", drop_cnt, 1);
        for (int i = 1; i < 4; i++) pop_chk("ovf_pop", tbl[i].edges, tbl[i].level);
        pop_chk("pp_new", 4'h8, 4'hF);
        chk("drain_valid", evt_valid, 0);
        chk("hold_edges", evt_edges, 4'h8);
        chk("hold_level", evt_level, 4'hF);

        acc.delete();
        tog = 4'b0001;
        tick();
        tog = 4'h0;
        mask_wr = 1'b1;
        mask_val = 4'h3;
        tick();
        mask_wr = 1'b0;
        wait_idle();
        chk("mp_w2", acc_at(0), 8'hA3);
        chk("mp_rd3", acc_at(1), 8'h30);
        chk("mp_w3", acc_at(2), 8'hB0);
        chk("mp_rd0", acc_at(3), 8'h00);
        pop_chk("mp", 4'h1, 4'hE);

        acc.delete();
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        repeat (6) tick();
        chk("sp_n", acc.size(), 1);
        chk("sp_rd3", acc_at(0), 8'h30);
        chk("sp_valid", evt_valid, 0);
        chk("sp_busy", busy, 0);

        acc.delete();
        tog = 4'b0010;
        tick();
        tog = 4'h0;
        repeat (2) tick();
        mask_wr = 1'b1;
        mask_val = 4'h5;
        tick();
        mask_val = 4'hC;
        tick();
        mask_wr = 1'b0;
        wait_idle();
        repeat (3) tick();
        chk("ml_n", acc.size(), 4);
        chk("ml_w2", acc_at(3), 8'hAC);
        pop_chk("ml", 4'h2, 4'hC);

        svc(4'b0100);
        svc(4'b1000);
        chk("rq_head", evt_edges, 4'h4);
        tog = 4'b0100;
        tick();
        tog = 4'h0;
        repeat (4) tick();
        chk("rq_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outs("mid");
        repeat (2) tick();
        acc.delete();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("re_n", acc.size(), 2);
        chk("re_w2", acc_at(0), 8'hAF);
        chk("re_w3", acc_at(1), 8'hB0);
        chk("re_busy", busy, 0);
        chk("re_valid", evt_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
